key_step_conditioner: RTL

- Front-end conditioner for the four active-low pushbuttons, sitting directly upstream of the lab top-level control logic.
- Per key: synchronises, debounces, and produces a clean level plus a one-cycle press pulse.
- For the increment key (KEY[0]) and decrement key (KEY[1]) it also produces auto-repeating step pulses, so the range-browsing logic can consume single-cycle steps instead of free-running counter gating.

---
 rtl/key_pkg.sv | 23 ++
 rtl/key_debounce.sv | 67 ++++++
 rtl/key_step_conditioner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the pushbutton conditioner.
//   KEY_*          : bit positions of the lab pushbuttons within key_n.
//   repeat_state_t : states of the shared up/down auto-repeat FSM.
//   cnt_width()    : bits needed for a counter that runs 0..n-1.
package key_pkg;

    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_RESET = 2;
    localparam int unsigned KEY_GO    = 3;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCKOUT
    } repeat_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one pushbutton channel.
//   clk, reset      : system clock, synchronous active-high reset.
//   key_n_i         : raw active-low button, asynchronous to clk.
//   pressed_o       : debounced level, 1 = held.
//   press_pulse_o   : one cycle high in the first cycle pressed_o reads 1.
//   release_pulse_o : one cycle high in the first cycle pressed_o reads 0.
//   pressed_nxt_o   : value pressed_o takes after the coming edge.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic pressed_nxt_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          raw_s;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, release_q;

    always_comb begin
        raw_s   = ~sync2_q;
        level_d = level_q;
        cnt_d   = '0;
        if (raw_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign pressed_o       = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign pressed_nxt_o   = level_d;

endmodule

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: debounces NKEYS active-low pushbuttons and turns
// KEY_UP / KEY_DOWN into single-cycle, auto-repeating step pulses.
//   clk, reset    : system clock, synchronous active-high reset.
//   key_n         : raw active-low buttons.
//   pressed       : debounced levels, 1 = held.
//   press_pulse   : one-cycle pulse per accepted press.
//   release_pulse : one-cycle pulse per accepted release.
//   step_up       : increment step (KEY_UP), first pulse with the press,
//                   then after REPEAT_DELAY, then every REPEAT_PERIOD.
//   step_down     : decrement step (KEY_DOWN), same timing.
// Pressing both direction keys locks stepping out until both are released.
module key_step_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NKEYS           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] pressed,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] release_pulse,
    output logic             step_up,
    output logic             step_down
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_width(RMAX);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    // The FSM works on next-cycle levels so its registered steps land in the
    // same cycle as the matching press_pulse / level change.
    logic [1:0] lvl_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NKEYS; gi++) begin : g_key
            if (gi < 2) begin : g_step
                key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                    .clk            (clk),
                    .reset          (reset),
                    .key_n_i        (key_n[gi]),
                    .pressed_o      (pressed[gi]),
                    .press_pulse_o  (press_pulse[gi]),
                    .release_pulse_o(release_pulse[gi]),
                    .pressed_nxt_o  (lvl_nxt[gi])
                );
            end else begin : g_plain
                logic nxt_unused;
                key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                    .clk            (clk),
                    .reset          (reset),
                    .key_n_i        (key_n[gi]),
                    .pressed_o      (pressed[gi]),
                    .press_pulse_o  (press_pulse[gi]),
                    .release_pulse_o(release_pulse[gi]),
                    .pressed_nxt_o  (nxt_unused)
                );
            end
        end
    endgenerate

    repeat_state_t state_q, state_d;
    logic          dir_q, dir_d;   // 0 = up, 1 = down
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          up_d, dn_d;
    logic          up_nxt, dn_nxt, up_pp, dn_pp, own_held, other_held, at_last;

    always_comb begin
        up_nxt     = lvl_nxt[KEY_UP];
        dn_nxt     = lvl_nxt[KEY_DOWN];
        up_pp      = up_nxt & ~pressed[KEY_UP];
        dn_pp      = dn_nxt & ~pressed[KEY_DOWN];
        own_held   = dir_q ? dn_nxt : up_nxt;
        other_held = dir_q ? up_nxt : dn_nxt;
        at_last    = (state_q == DELAY) ? (rcnt_q == DELAY_LAST) : (rcnt_q == PERIOD_LAST);
        state_d    = state_q;
        dir_d      = dir_q;
        rcnt_d     = rcnt_q;
        up_d       = 1'b0;
        dn_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_pp && !dn_nxt) begin
                    up_d    = 1'b1;
                    dir_d   = 1'b0;
                    rcnt_d  = '0;
                    state_d = DELAY;
                end else if (dn_pp && !up_nxt) begin
                    dn_d    = 1'b1;
                    dir_d   = 1'b1;
                    rcnt_d  = '0;
                    state_d = DELAY;
                end else if (up_pp || dn_pp) begin
                    state_d = LOCKOUT;
                end
            end
            DELAY, REPEAT: begin
                if (other_held) begin
                    state_d = LOCKOUT;
                end else if (!own_held) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    up_d    = ~dir_q;
                    dn_d    = dir_q;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            LOCKOUT: begin
                if (!up_nxt && !dn_nxt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            rcnt_q    <= '0;
            step_up   <= 1'b0;
            step_down <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rcnt_q    <= rcnt_d;
            step_up   <= up_d;
            step_down <= dn_d;
        end
    end

endmodule
